// File: rtl/pulse_width_counter_if.sv
// ---------------------------------------------------------------------------
// pulse_width_counter_if
//   Groups the Tiny Tapeout user-macro pin bundle for pulse_width_counter.
//   Ports carried:
//     ena      1  design-selected strobe (ignored by the design)
//     ui_in    8  [0] pulse in, [1] polarity, [2] sync clear, [4:3] prescale sel
//     uio_in   8  unused bidirectional inputs
//     uo_out   8  result[7:0]
//     uio_out  8  result[15:8]
//     uio_oe   8  bidirectional output enables (always all outputs)
//   Modports:
//     master  drives the inputs and observes the outputs (harness side)
//     slave   consumes the inputs and drives the outputs (design side)
// ---------------------------------------------------------------------------
interface pulse_width_counter_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ena,
    output ui_in,
    output uio_in,
    input  uo_out,
    input  uio_out,
    input  uio_oe
  );

  modport slave (
    input  ena,
    input  ui_in,
    input  uio_in,
    output uo_out,
    output uio_out,
    output uio_oe
  );
endinterface

// File: rtl/pulse_width_counter.sv
// ---------------------------------------------------------------------------
// pulse_width_counter
//   Measures the active width of pulses on ui_in[0] in clock cycles divided
//   by a selectable prescaler and latches a 16-bit result at the end of
//   each pulse. The result holds until the next pulse completes.
//
//   Ports:
//     clk    system clock
//     rst_n  asynchronous active-low reset
//     bus    pulse_width_counter_if.slave pin bundle:
//              ui_in[0]   pulse input (asynchronous, synchronised here)
//              ui_in[1]   polarity, 1 = measure low pulses
//              ui_in[2]   synchronous clear of count, phase and result
//              ui_in[4:3] prescale 00:/1 01:/16 10:/256 11:/4096
//              uo_out     result[7:0]
//              uio_out    result[15:8]
//              uio_oe     constant 8'hFF
//              ena, uio_in, ui_in[7:5] unused
//
//   Configuration macro:
//     PWC_SATURATE_EN  when defined the count sticks at 16'hFFFF;
//                      otherwise it wraps modulo 2^16.
// ---------------------------------------------------------------------------
module pulse_width_counter (
  input  logic                        clk,
  input  logic                        rst_n,
  pulse_width_counter_if.slave        bus
);

  logic        sync1;
  logic        sync2;
  logic        prev;
  logic        level;
  logic        rise;
  logic        fall;
  logic [11:0] p;
  logic [11:0] p_last;
  logic [15:0] count;
  logic [15:0] count_inc;
  logic [15:0] result;
  logic        unused_ok;

  // Polarity is applied after the synchroniser, so toggling ui_in[1]
  // mid-pulse flips level and is seen as a genuine edge.
  assign level = sync2 ^ bus.ui_in[1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

  // Terminal value of the phase counter (D-1) for the selected prescaler.
  always_comb begin
    p_last = 12'd0;
    case (bus.ui_in[4:3])
      2'b00:   p_last = 12'd0;
      2'b01:   p_last = 12'd15;
      2'b10:   p_last = 12'd255;
      default: p_last = 12'd4095;
    endcase
  end

`ifdef PWC_SATURATE_EN
  assign count_inc = (count == 16'hFFFF) ? count : count + 16'd1;
`else
  assign count_inc = count + 16'd1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= bus.ui_in[0];
      sync2 <= sync1;
      prev  <= level;
    end
  end

  // The rise cycle is itself an active cycle, so it already contributes one
  // phase step; with /1 that step is a whole count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p      <= 12'd0;
      count  <= 16'd0;
      result <= 16'd0;
    end else if (bus.ui_in[2]) begin
      p      <= 12'd0;
      count  <= 16'd0;
      result <= 16'd0;
    end else if (rise) begin
      if (p_last == 12'd0) begin
        p     <= 12'd0;
        count <= 16'd1;
      end else begin
        p     <= 12'd1;
        count <= 16'd0;
      end
    end else if (fall) begin
      result <= count;
      count  <= 16'd0;
      p      <= 12'd0;
    end else if (level) begin
      if (p == p_last) begin
        p     <= 12'd0;
        count <= count_inc;
      end else begin
        p <= p + 12'd1;
      end
    end else begin
      p     <= 12'd0;
      count <= 16'd0;
    end
  end

  assign bus.uo_out  = result[7:0];
  assign bus.uio_out = result[15:8];
  assign bus.uio_oe  = 8'hFF;

  assign unused_ok = &{1'b0, bus.ena, bus.uio_in, bus.ui_in[7:5]};

endmodule

// File: tb/tb_pulse_width_counter.sv
// ---------------------------------------------------------------------------
// tb_pulse_width_counter
//   Directed bench for pulse_width_counter: a table of pulse widths and
//   prescaler settings with hand-computed results, followed by hand-written
//   sequences for polarity edges, wrap/saturation, clear and reset.
// ---------------------------------------------------------------------------
module tb_pulse_width_counter;

  typedef struct {
    logic [1:0]  sel;
    int          width;
    logic [15:0] exp_result;
    string       name;
  } vec_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  logic [15:0] prev_exp;
  logic [15:0] wrap_exp;
  vec_t vecs[8];

  pulse_width_counter_if bus ();

  pulse_width_counter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges and land 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] got,
                             input logic [15:0] exp_val);
    total = total + 1;
    if (got !== exp_val) begin
      bad = bad + 1;
      $display("[TB] FAIL %s: got=%0d (0x%04h) expected=%0d (0x%04h)",
               name, got, got, exp_val, exp_val);
    end
  endtask

  // Drives an active-high pulse of the given width in clock cycles.
  task automatic applyStimulus(input logic [1:0] sel, input int width);
    bus.ui_in[4:3] = sel;
    bus.ui_in[0]   = 1'b1;
    tick(width);
    bus.ui_in[0]   = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;

    vecs[0] = '{2'b00, 100,  16'd100, "sel00_w100"};
    vecs[1] = '{2'b00, 1,    16'd1,   "sel00_w1"};
    vecs[2] = '{2'b01, 1000, 16'd62,  "sel01_w1000"};
    vecs[3] = '{2'b01, 15,   16'd0,   "sel01_w15"};
    vecs[4] = '{2'b01, 16,   16'd1,   "sel01_w16"};
    vecs[5] = '{2'b10, 1000, 16'd3,   "sel10_w1000"};
    vecs[6] = '{2'b11, 4095, 16'd0,   "sel11_w4095"};
    vecs[7] = '{2'b11, 4096, 16'd1,   "sel11_w4096"};

`ifdef PWC_SATURATE_EN
    wrap_exp = 16'hFFFF;
`else
    wrap_exp = 16'd4464;
`endif

    bus.ena    = 1'b1;
    bus.uio_in = 8'h00;
    bus.ui_in  = 8'h00;
    rst_n      = 1'b0;

    #2;
    checkOutput("reset_result", {bus.uio_out, bus.uo_out}, 16'd0);
    checkOutput("reset_oe", {8'h00, bus.uio_oe}, 16'h00FF);
    tick(2);
    rst_n = 1'b1;
    tick(10);
    checkOutput("idle_after_reset", {bus.uio_out, bus.uo_out}, 16'd0);

    prev_exp = 16'd0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].sel, vecs[i].width);
      tick(2);
      checkOutput({vecs[i].name, "_latency"}, {bus.uio_out, bus.uo_out}, prev_exp);
      tick(1);
      checkOutput(vecs[i].name, {bus.uio_out, bus.uo_out}, vecs[i].exp_result);
      prev_exp = vecs[i].exp_result;
      tick(3);
    end

    // Switching polarity while the synchroniser still holds the old level
    // produces a 2-cycle active window that is measured as a real pulse.
    bus.ui_in[4:3] = 2'b00;
    bus.ui_in[1]   = 1'b1;
    bus.ui_in[0]   = 1'b1;
    tick(3);
    checkOutput("pol_switch_edge", {bus.uio_out, bus.uo_out}, 16'd2);
    tick(3);

    bus.ui_in[0] = 1'b0;
    tick(37);
    bus.ui_in[0] = 1'b1;
    tick(2);
    checkOutput("pol_low37_latency", {bus.uio_out, bus.uo_out}, 16'd2);
    tick(1);
    checkOutput("pol_low37", {bus.uio_out, bus.uo_out}, 16'd37);
    tick(40);
    checkOutput("pol_high_ignored", {bus.uio_out, bus.uo_out}, 16'd37);

    bus.ui_in[1] = 1'b0;
    bus.ui_in[0] = 1'b0;
    tick(3);
    checkOutput("pol_switch_back", {bus.uio_out, bus.uo_out}, 16'd2);
    tick(3);

    applyStimulus(2'b00, 70000);
    tick(3);
    checkOutput("long_pulse_wrap_sat", {bus.uio_out, bus.uo_out}, wrap_exp);
    tick(3);

    bus.ui_in[2] = 1'b1;
    tick(1);
    bus.ui_in[2] = 1'b0;
    checkOutput("sync_clear", {bus.uio_out, bus.uo_out}, 16'd0);
    tick(3);

    // Clear one cycle mid-pulse: 21 active cycles, 12 of them after the clear.
    bus.ui_in[0] = 1'b1;
    tick(10);
    bus.ui_in[2] = 1'b1;
    tick(1);
    bus.ui_in[2] = 1'b0;
    checkOutput("clear_mid_result", {bus.uio_out, bus.uo_out}, 16'd0);
    tick(10);
    bus.ui_in[0] = 1'b0;
    tick(3);
    checkOutput("clear_mid_remainder", {bus.uio_out, bus.uo_out}, 16'd12);
    tick(3);

    // Reset mid-pulse: only the part after reset release is measured.
    bus.ui_in[0] = 1'b1;
    tick(20);
    rst_n = 1'b0;
    #1;
    checkOutput("reset_mid", {bus.uio_out, bus.uo_out}, 16'd0);
    tick(1);
    rst_n = 1'b1;
    tick(10);
    bus.ui_in[0] = 1'b0;
    tick(3);
    checkOutput("reset_remainder", {bus.uio_out, bus.uo_out}, 16'd10);
    tick(3);

    applyStimulus(2'b00, 25);
    tick(3);
    checkOutput("after_reset_w25", {bus.uio_out, bus.uo_out}, 16'd25);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
